// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit_pkg
// Brief    : Shared fetch-stage constants and the IF/ID bundle type.
// Revision : 1.0
// ============================================================================
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // ID/EX reuses this bundle, so keep the field order stable.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pipe_reg
// Brief    : IF/ID bundle register with load, hold and bubble controls.
// Revision : 1.0
// ============================================================================
module if_id_pipe_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  localparam if_id_t C_BUBBLE = '{inst: NOP_INST, pc: 32'h0, pred_pc: 32'h0, valid: 1'b0};

  if_id_t r_bundle_q;

  // Bubble outranks load so a squash can never be overridden by a fetch.
  always_ff @(posedge clk) begin
    if (reset || bubble_i) begin
      r_bundle_q <= C_BUBBLE;
    end else if (load_i) begin
      r_bundle_q <= d_i;
    end
  end

  assign q_o = r_bundle_q;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : IF-stage PC register, fetch priority control, IF/ID register
//            and fetch/squash performance counters.
// Revision : 1.0
// ============================================================================
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_predict,
  input  logic             redirect,
  input  logic [31:0]      pc_correct,
  input  logic             stall,
  input  logic             halt_req,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      current_pc,
  output logic [31:0]      IF_ID_inst,
  output logic [31:0]      IF_ID_pc,
  output logic [31:0]      IF_ID_pred_pc,
  output logic             IF_ID_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] squash_count
);

  logic [31:0]      r_pc_q,     w_pc_d;
  logic             r_halted_q, w_halted_d;
  logic [CNT_W-1:0] r_fetch_q,  w_fetch_d;
  logic [CNT_W-1:0] r_squash_q, w_squash_d;
  logic             w_load;
  logic             w_bubble;
  logic [31:0]      w_pred_al;
  logic [31:0]      w_correct_al;
  if_id_t           w_if_id_d;
  if_id_t           w_if_id_q;

  assign w_pred_al    = align_word(pc_predict);
  assign w_correct_al = align_word(pc_correct);

  // Priority: redirect > halt (sticky or requested) > stall > advance.
  always_comb begin
    w_pc_d     = r_pc_q;
    w_halted_d = r_halted_q;
    w_fetch_d  = r_fetch_q;
    w_squash_d = r_squash_q;
    w_load     = 1'b0;
    w_bubble   = 1'b0;
    if (redirect) begin
      w_pc_d     = w_correct_al;
      w_halted_d = 1'b0;
      w_squash_d = r_squash_q + 1'b1;
      w_bubble   = 1'b1;
    end else if (r_halted_q || halt_req) begin
      w_halted_d = 1'b1;
      w_bubble   = 1'b1;
    end else if (!stall) begin
      w_pc_d    = w_pred_al;
      w_fetch_d = r_fetch_q + 1'b1;
      w_load    = 1'b1;
    end
  end

  assign w_if_id_d = '{inst: imem_inst, pc: r_pc_q, pred_pc: w_pred_al, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_q     <= align_word(RESET_PC);
      r_halted_q <= 1'b0;
      r_fetch_q  <= '0;
      r_squash_q <= '0;
    end else begin
      r_pc_q     <= w_pc_d;
      r_halted_q <= w_halted_d;
      r_fetch_q  <= w_fetch_d;
      r_squash_q <= w_squash_d;
    end
  end

  if_id_pipe_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_load),
    .bubble_i (w_bubble),
    .d_i      (w_if_id_d),
    .q_o      (w_if_id_q)
  );

  assign current_pc    = r_pc_q;
  assign IF_ID_inst    = w_if_id_q.inst;
  assign IF_ID_pc      = w_if_id_q.pc;
  assign IF_ID_pred_pc = w_if_id_q.pred_pc;
  assign IF_ID_valid   = w_if_id_q.valid;
  assign halted        = r_halted_q;
  assign fetch_count   = r_fetch_q;
  assign squash_count  = r_squash_q;

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
IF-stage PC register and IF/ID pipeline register for the 5-stage core.
- Each cycle it presents current_pc to instruction memory and the branch prediction unit, then advances to the predicted next PC.
- It applies EX-stage misprediction redirects, load-use stalls and halt.
- It carries the predicted next PC down the pipe in IF_ID_pred_pc, so EX can compare it with the resolved target and report prediction success back to the predictor.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction word injected into IF/ID on bubble/squash (addi x0,x0,0)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
pc_predict  input  32  next-PC prediction for current_pc from branch prediction unit
redirect  input  1  EX-stage misprediction; fetch must restart at pc_correct
pc_correct  input  32  resolved next PC of the instruction in EX
stall  input  1  hazard unit request to hold IF and IF/ID
halt_req  input  1  halting instruction decoded in ID
imem_inst  input  32  instruction word read combinationally at current_pc
current_pc  output  32  PC of the instruction being fetched
IF_ID_inst  output  32  latched instruction
IF_ID_pc  output  32  PC of latched instruction
IF_ID_pred_pc  output  32  predicted next PC recorded at fetch
IF_ID_valid  output  1  latched instruction is real (not bubble)
halted  output  1  sticky: fetch stopped by halt
fetch_count  output  CNT_W  instructions accepted into IF/ID
squash_count  output  CNT_W  redirect cycles taken

Behaviour:
- Clock and reset: all state updates on posedge clk. reset is synchronous, active-high.
- Reset values:
  - current_pc=RESET_PC
  - IF_ID_inst=NOP_INST
  - IF_ID_pc=0, IF_ID_pred_pc=0, IF_ID_valid=0
  - halted=0
  - both counters 0
  - Reset mid-operation discards all in-flight state in one cycle.
- Address alignment: the low 2 bits of pc_predict and pc_correct are forced to 00 before use. current_pc[1:0] is always 00.
- Cycle priority, evaluated per posedge, first match wins:
  1. reset: load reset values.
  2. redirect:
     - current_pc<=pc_correct (aligned)
     - IF_ID <= {NOP_INST, 0, 0, valid=0}, squashing the wrong-path fetch
     - squash_count+1
     - redirect overrides stall, halt_req and halted; halted is not set that cycle
     - a halted fetch restarts only if redirect arrives; halted is cleared on redirect
  3. halted | halt_req:
     - halted<=1
     - current_pc holds
     - IF_ID <= bubble (NOP_INST, valid=0)
     - fetch_count unchanged
  4. stall: current_pc, IF_ID_* and counters all hold.
  5. normal advance:
     - IF_ID_inst<=imem_inst
     - IF_ID_pc<=current_pc
     - IF_ID_pred_pc<=pc_predict (aligned)
     - IF_ID_valid<=1
     - current_pc<=pc_predict (aligned)
     - fetch_count+1
- Latency: an instruction fetched at cycle N appears on IF_ID_* in cycle N+1. A redirect at cycle N fetches pc_correct in cycle N+1, and its instruction appears in IF/ID in cycle N+2.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Outputs are registered only. No combinational path from any input to any output.
- IF_ID_pred_pc is the exact value EX compares against pc_correct. Prediction success = (IF_ID_pred_pc carried to EX == pc_correct).

Decomposition:
- Shared package: NOP_INST, RESET_PC, and the IF/ID bundle typedef {inst, pc, pred_pc, valid}; ID/EX reuses that typedef.
- One sub-module, if_id_pipe_reg: the bundle register with load/hold/bubble controls.
- PC register, priority logic and counters stay in fetch_pc_unit.

Test Plan:
- Reset then release, pc_predict=current_pc+4, imem=pc-indexed words → current_pc 0,4,8,12. IF_ID_pc lags by one cycle, IF_ID_valid=1 from 2nd cycle. fetch_count=3 after 3 advances.
- Predicted taken: at current_pc=0x10, pc_predict=0x40 → next current_pc=0x40, IF_ID_pc=0x10, IF_ID_pred_pc=0x40.
- redirect=1 with stall=1, pc_correct=0x24 → current_pc=0x24, IF_ID_inst=0x00000013, valid=0, squash_count+1, fetch_count unchanged.
- stall held 3 cycles at current_pc=0x08 → current_pc and IF_ID_* unchanged all 3 cycles, then advance resumes to pc_predict.
- halt_req pulse at current_pc=0x30 → halted=1 sticky, current_pc stays 0x30, IF_ID_valid=0 forever. A later redirect to 0x50 clears halted and fetches 0x50. halt_req and redirect in the same cycle → halted stays 0.
- pc_correct=0x27 → current_pc=0x24. Reset asserted while halted and mid-stall → all outputs return to reset values next cycle.
